// File: rtl/opcode_selector.sv
// opcode_selector: debounced button bank that latches a priority-encoded opcode
module opcode_selector #(
  parameter int N_OPS     = 4,
  parameter int OPCODE_W  = 2,
  parameter int DB_CYCLES = 4,
  parameter int LOCK      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_OPS-1:0]    btn_in,
  input  logic                btn_clear,
  output logic [OPCODE_W-1:0] opcode_out,
  output logic                opcode_valid,
  output logic                opcode_strobe,
  output logic [N_OPS-1:0]    btn_state
);
  localparam int N  = N_OPS + 1;
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [N-1:0]          r_s1, r_s2, r_db, r_prev;
  logic [CW-1:0]         r_cnt [N];
  logic [N-1:0]          w_raw, w_evt;
  logic [N_OPS-1:0]      w_op_evt;
  logic                  w_clr_evt, w_take;
  logic [OPCODE_W-1:0]   w_idx;
  logic [OPCODE_W-1:0]   r_op;
  logic                  r_valid, r_strobe;

  assign w_raw     = {btn_clear, btn_in};
  assign w_evt     = r_db & ~r_prev;
  assign w_op_evt  = w_evt[N_OPS-1:0];
  assign w_clr_evt = w_evt[N_OPS];
  assign w_take    = (|w_op_evt) && ((LOCK == 0) || !r_valid);

  // two-flop synchronisers plus previous debounced level for rise detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= w_raw;
      r_s2   <= r_s1;
      r_prev <= r_db;
    end

  // per-channel debounce: level flips once the mismatch has persisted DB_CYCLES cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_db <= '0;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (r_s2[i] == r_db[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CW'(DB_CYCLES)) begin
          r_db[i]  <= ~r_db[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end

  // lowest-indexed press event wins
  always_comb begin
    w_idx = '0;
    for (int i = N_OPS - 1; i >= 0; i--) if (w_op_evt[i]) w_idx = OPCODE_W'(i);
  end

  // selection register: clear dominates, otherwise accept presses unless locked
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_op     <= '0;
      r_valid  <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= !w_clr_evt && w_take;
      if (w_clr_evt) begin
        r_op    <= '0;
        r_valid <= 1'b0;
      end else if (w_take) begin
        r_op    <= w_idx;
        r_valid <= 1'b1;
      end
    end

  assign opcode_out    = r_op;
  assign opcode_valid  = r_valid;
  assign opcode_strobe = r_strobe;
  assign btn_state     = r_db[N_OPS-1:0];
endmodule
